// File: rtl/serializer_pkg.sv
// Shared types for the row serializer: FSM state encoding and default row width.
// ST_GAP exists only when ROW_SER_GAP_EN is defined.
package serializer_pkg;

  localparam int DEFAULT_ROW_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3
`ifdef ROW_SER_GAP_EN
    , ST_GAP = 3'd4
`endif
  } row_ser_state_e;

endpackage

// File: rtl/parallel_to_serial.sv
// Loadable shift register paired with row_serializer_ctrl (active-high reset).
// Each shift moves the next LSB onto serial_out, so the first shift after a load presents bit 0.
module parallel_to_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_en,
  input  logic             shift_en,
  output logic             serial_out
);

  logic [WIDTH-1:0] sreg_q;
  logic             sout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      sout_q <= 1'b0;
    end else if (load_en) begin
      sreg_q <= data_in;
    end else if (shift_en) begin
      sout_q <= sreg_q[0];
      sreg_q <= sreg_q >> 1;
    end
  end

  assign serial_out = sout_q;

endmodule

// File: rtl/row_serializer_ctrl.sv
// Row serializer controller: accepts a row word, drives an external shift register LSB first.
// Define ROW_SER_GAP_EN to insert GAP_CYCLES idle cycles between frames.
module row_serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_ROW_WIDTH,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] row_data,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic             flush,
  input  logic             serial_ready,
  output logic [WIDTH-1:0] p2s_data,
  output logic             p2s_load_en,
  output logic             p2s_shift_en,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output row_ser_state_e   state_o
);

  // Handshakes: a row transfers on a rising edge where row_valid && row_ready;
  // a serial bit is consumed on a rising edge where bit_valid && serial_ready.

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("GAP_CYCLES must be non-negative");
  end

  row_ser_state_e   state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             bv_q, bv_d;
  logic             ready_c, load_c, shift_c;

`ifdef ROW_SER_GAP_EN
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [GW-1:0] gap_q, gap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gap_q <= '0;
    else      gap_q <= gap_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      bv_q    <= bv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    bv_d    = bv_q;
    ready_c = 1'b0;
    load_c  = 1'b0;
    shift_c = 1'b0;
`ifdef ROW_SER_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (row_valid && !flush) begin
          data_d  = row_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        idx_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // A shift refills the output slot, so an unconsumed bit blocks it.
        shift_c = !bv_q || serial_ready;
        if (shift_c) begin
          idx_d = bv_q ? idx_q + CW'(1) : '0;
          if (idx_d == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bv_q && serial_ready) begin
          idx_d = '0;
`ifdef ROW_SER_GAP_EN
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef ROW_SER_GAP_EN
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (shift_c)                  bv_d = 1'b1;
    else if (bv_q && serial_ready) bv_d = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      bv_d    = 1'b0;
      idx_d   = '0;
`ifdef ROW_SER_GAP_EN
      gap_d   = '0;
`endif
    end
  end

  // Gating with rst keeps row_ready low while reset is held; gating with flush
  // keeps the handshake honest since flush blocks acceptance.
  assign row_ready    = ready_c && !flush && rst;
  assign p2s_data     = data_q;
  assign p2s_load_en  = load_c;
  assign p2s_shift_en = shift_c;
  assign bit_valid    = bv_q;
  assign frame_start  = bv_q && (idx_q == '0);
  assign frame_last   = bv_q && (idx_q == LAST_IDX);
  assign busy         = (state_q != ST_IDLE) || bv_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_row_serializer_ctrl.sv
// Bench for row_serializer_ctrl paired with parallel_to_serial, WIDTH=3.
// Honours ROW_SER_GAP_EN in its reference model.
module tb_row_serializer_ctrl;
  import serializer_pkg::*;

  localparam int W = 3;
`ifdef ROW_SER_GAP_EN
  localparam int TB_GAP = 2;
`else
  localparam int TB_GAP = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   row_data;
  logic           row_valid;
  logic           row_ready;
  logic           flush;
  logic           serial_ready;
  logic [W-1:0]   p2s_data;
  logic           p2s_load_en;
  logic           p2s_shift_en;
  logic           bit_valid;
  logic           frame_start;
  logic           frame_last;
  logic           busy;
  row_ser_state_e dbg_state;
  logic           p2s_rst;
  logic           serial_bit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign p2s_rst = ~rst;

  row_serializer_ctrl #(.WIDTH(W), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .flush(flush), .serial_ready(serial_ready),
    .p2s_data(p2s_data), .p2s_load_en(p2s_load_en), .p2s_shift_en(p2s_shift_en),
    .bit_valid(bit_valid), .frame_start(frame_start), .frame_last(frame_last),
    .busy(busy), .state_o(dbg_state)
  );

  parallel_to_serial #(.WIDTH(W)) u_p2s (
    .clk(clk), .rst(p2s_rst), .data_in(p2s_data), .load_en(p2s_load_en),
    .shift_en(p2s_shift_en), .serial_out(serial_bit)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of W bits; bit 0 appears two cycles
  // after acceptance, each later bit appears the cycle after its predecessor
  // is consumed, and the controller is free again once the last bit is taken.
  logic         exp_q[$];
  logic         m_idle;
  logic         m_valid;
  int           m_wait;
  int           m_idx;
  int           m_gap;
  logic [W-1:0] m_word;

  task automatic model_reset();
    m_idle  = 1'b1;
    m_valid = 1'b0;
    m_wait  = 0;
    m_idx   = 0;
    m_gap   = 0;
    m_word  = '0;
    exp_q.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rst_row_ready", 32'(row_ready), 32'd0);
      check_eq("rst_bit_valid", 32'(bit_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_load_en", 32'(p2s_load_en), 32'd0);
      check_eq("rst_shift_en", 32'(p2s_shift_en), 32'd0);
      check_eq("rst_p2s_data", 32'(p2s_data), 32'd0);
      model_reset();
    end else begin
      check_eq("row_ready", 32'(row_ready), 32'(m_idle && m_gap == 0 && !flush));
      check_eq("busy", 32'(busy), 32'(!m_idle || m_gap > 0 || m_valid));
      check_eq("p2s_data", 32'(p2s_data), 32'(m_word));
      check_eq("load_en", 32'(p2s_load_en), 32'(m_wait == 2));
      check_eq("shift_en", 32'(p2s_shift_en),
               32'(m_wait == 1 || (m_valid && serial_ready && m_idx < W - 1)));
      check_eq("bit_valid", 32'(bit_valid), 32'(m_valid));
      check_eq("frame_start", 32'(frame_start), 32'(m_valid && m_idx == 0));
      check_eq("frame_last", 32'(frame_last), 32'(m_valid && m_idx == W - 1));
      if (m_valid) begin
        if (exp_q.size() == 0) check_eq("exp_q_empty", 32'd1, 32'd0);
        else                   check_eq("serial_bit", 32'(serial_bit), 32'(exp_q[0]));
      end

      if (flush) begin
        m_idle  = 1'b1;
        m_valid = 1'b0;
        m_wait  = 0;
        m_idx   = 0;
        m_gap   = 0;
        exp_q.delete();
      end else if (m_idle) begin
        if (m_gap > 0) begin
          m_gap--;
        end else if (row_valid) begin
          m_word = row_data;
          m_idle = 1'b0;
          m_wait = 2;
          for (int i = 0; i < W; i++) exp_q.push_back(row_data[i]);
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_idx   = 0;
        end
      end else if (m_valid && serial_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_idx == W - 1) begin
          m_valid = 1'b0;
          m_idle  = 1'b1;
          m_gap   = TB_GAP;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic drive(input logic rv, input logic [W-1:0] rd, input logic fl, input logic sr);
    row_valid    = rv;
    row_data     = rd;
    flush        = fl;
    serial_ready = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst          = 1'b0;
    row_valid    = 1'b0;
    row_data     = '0;
    flush        = 1'b0;
    serial_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    // Single row, sink always ready.
    drive(1'b1, 3'b011, 1'b0, 1'b1);
    idle_cycles(7);

    // Sink stalls for two cycles while bit 0 is presented.
    drive(1'b1, 3'b101, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    idle_cycles(6);

    // Back-to-back rows with row_valid held; the second word waits for IDLE.
    drive(1'b1, 3'b110, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 3'b001, 1'b0, 1'b1);
    idle_cycles(7);

    // Flush while bit 1 is presented, then a fresh row.
    drive(1'b1, 3'b111, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b1, 3'b010, 1'b0, 1'b1);
    idle_cycles(7);

    // Asynchronous reset in the middle of a shift.
    drive(1'b1, 3'b110, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("async_rst_bit_valid", 32'(bit_valid), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_row_ready", 32'(row_ready), 32'd0);
    check_eq("async_rst_p2s_data", 32'(p2s_data), 32'd0);
    check_eq("async_rst_frame_start", 32'(frame_start), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("post_rst_row_ready", 32'(row_ready), 32'd1);
    idle_cycles(2);

    // Randomized traffic: rows, sink stalls and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
    end
    idle_cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
